// File: rtl/sys_ctrl_pkg.sv
// Shared command codes, FSM state encoding and helpers for the frame-driven system controller.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR    = 8'hAA;
    localparam logic [7:0] CMD_RF_RD    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
    localparam logic [7:0] CMD_BURST_WR = 8'hEE;
    localparam logic [7:0] CMD_BURST_RD = 8'hFF;

    localparam int unsigned ALU_ADDR_A = 0;
    localparam int unsigned ALU_ADDR_B = 1;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN,
        RF_WR, RF_RD, WAIT_RD, PUSH, ALU_ISSUE, WAIT_ALU, PUSH_LO, PUSH_HI
    } state_t;

    function automatic logic is_get_state(input state_t s);
        return s inside {GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN};
    endfunction

    function automatic logic is_known_cmd(input logic [7:0] b);
        return b inside {CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP, CMD_BURST_WR, CMD_BURST_RD};
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout: reloads while idle or on each byte, counts down while run is high.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] remain_q, remain_d;

    always_comb begin
        remain_d = remain_q;
        if (!run || kick) begin
            remain_d = CW'(TIMEOUT_CYCLES);
        end else if (remain_q != '0) begin
            remain_d = remain_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) remain_q <= CW'(TIMEOUT_CYCLES);
        else         remain_q <= remain_d;
    end

    // terminal count: this is the TIMEOUT_CYCLES-th consecutive idle cycle
    assign expired = run && !kick && (remain_q == CW'(1));

endmodule

// File: rtl/sys_ctrl_burst.sv
// Byte-frame command decoder driving a register file, an ALU and a TX FIFO, with burst access.
// state     | meaning
// IDLE      | waiting for a command byte
// GET_*     | collecting frame bytes (addr, data, count, A, B, fun)
// RF_WR     | one-cycle register-file write strobe
// RF_RD     | one-cycle register-file read strobe
// WAIT_RD   | waiting for read data
// PUSH      | pushing read data to FIFO (stalls while full)
// ALU_ISSUE | one-cycle ALU start
// WAIT_ALU  | waiting for ALU result
// PUSH_LO/HI| pushing result low / high half
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic                    FIFO_FULL,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic [DATA_WIDTH-1:0]   Rd_D,
    input  logic                    Rd_D_Vld,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    WR_INC,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    output logic [DATA_WIDTH-1:0]   Wr_D,
    output logic [ADDR_WIDTH-1:0]   Addr,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic                    CLK_EN,
    output logic                    CLK_DIV_EN,
    output logic                    ERR
);
    state_t                  state_q, state_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wrd_q, wrd_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]              fun_q, fun_d;
    logic                    err_q, err_d;
    logic                    tmr_expired;
    logic [7:0]              rx_byte;

    assign rx_byte = RX_P_DATA[7:0];

    frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk_i  (CLK),
        .rst_ni (RST),
        .run    (is_get_state(state_q)),
        .kick   (RX_D_VLD),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wrd_d   = wrd_q;
        wdat_d  = wdat_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        fun_d   = fun_q;
        err_d   = 1'b0;

        // bytes arriving while busy are dropped but flagged
        if (state_q != IDLE && !is_get_state(state_q)) err_d = RX_D_VLD;

        if (is_get_state(state_q) && tmr_expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (RX_D_VLD) begin
                    if (is_known_cmd(rx_byte)) begin
                        cmd_d = rx_byte;
                        case (rx_byte)
                            CMD_ALU_OP:  state_d = GET_A;
                            CMD_ALU_NOP: state_d = GET_FUN;
                            default:     state_d = GET_ADDR;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
                GET_ADDR: if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    case (cmd_q)
                        CMD_RF_WR: state_d = GET_DATA;
                        CMD_RF_RD: state_d = RF_RD;
                        default:   state_d = GET_CNT;
                    endcase
                end
                GET_CNT: if (RX_D_VLD) begin
                    cnt_d = RX_P_DATA;
                    if (RX_P_DATA == '0)             state_d = IDLE;
                    else if (cmd_q == CMD_BURST_WR)  state_d = GET_DATA;
                    else                             state_d = RF_RD;
                end
                GET_DATA: if (RX_D_VLD) begin
                    wrd_d   = RX_P_DATA;
                    state_d = RF_WR;
                end
                GET_A: if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(ALU_ADDR_A);
                    wrd_d   = RX_P_DATA;
                    state_d = RF_WR;
                end
                GET_B: if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(ALU_ADDR_B);
                    wrd_d   = RX_P_DATA;
                    state_d = RF_WR;
                end
                GET_FUN: if (RX_D_VLD) begin
                    fun_d   = RX_P_DATA[3:0];
                    state_d = ALU_ISSUE;
                end
                RF_WR: begin
                    case (cmd_q)
                        CMD_ALU_OP:   state_d = (addr_q == ADDR_WIDTH'(ALU_ADDR_A)) ? GET_B : GET_FUN;
                        CMD_BURST_WR: begin
                            addr_d  = addr_q + 1'b1;
                            cnt_d   = cnt_q - 1'b1;
                            state_d = (cnt_q == DATA_WIDTH'(1)) ? IDLE : GET_DATA;
                        end
                        default:      state_d = IDLE;
                    endcase
                end
                RF_RD:   state_d = WAIT_RD;
                WAIT_RD: if (Rd_D_Vld) begin
                    wdat_d  = Rd_D;
                    state_d = PUSH;
                end
                PUSH: if (!FIFO_FULL) begin
                    if (cmd_q == CMD_BURST_RD) begin
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = (cnt_q == DATA_WIDTH'(1)) ? IDLE : RF_RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ALU_ISSUE: state_d = WAIT_ALU;
                WAIT_ALU: if (OUT_Valid) begin
                    wdat_d  = ALU_OUT[DATA_WIDTH-1:0];
                    hi_d    = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d = PUSH_LO;
                end
                PUSH_LO: if (!FIFO_FULL) begin
                    wdat_d  = hi_q;
                    state_d = PUSH_HI;
                end
                PUSH_HI: if (!FIFO_FULL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            wrd_q   <= '0;
            wdat_q  <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            fun_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wrd_q   <= wrd_d;
            wdat_q  <= wdat_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            fun_q   <= fun_d;
            err_q   <= err_d;
        end
    end

    assign WR_DATA    = wdat_q;
    assign WR_INC     = (state_q inside {PUSH, PUSH_LO, PUSH_HI}) && !FIFO_FULL;
    assign ALU_EN     = (state_q == ALU_ISSUE);
    assign ALU_FUN    = fun_q;
    assign Wr_D       = wrd_q;
    assign Addr       = addr_q;
    assign WrEn       = (state_q == RF_WR);
    assign RdEn       = (state_q == RF_RD);
    assign CLK_EN     = (state_q == ALU_ISSUE) || (state_q == WAIT_ALU);
    assign CLK_DIV_EN = 1'b1;
    assign ERR        = err_q;

endmodule

// File: doc/sys_ctrl_burst.md
SYS_CTRL_BURST -- requirements
Module: sys_ctrl_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning RX byte, RF data and FIFO word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle cycles allowed between frame bytes.
REQ-004 SHALL use one clock and an asynchronous active-low reset: CLK  input  1  system clock; RST  input  1  async active-low reset.
REQ-005 Inputs: RX_P_DATA DATA_WIDTH synced RX byte; RX_D_VLD 1 one-cycle byte strobe; FIFO_FULL 1 TX FIFO full; ALU_OUT 2*DATA_WIDTH result; OUT_Valid 1 result strobe; Rd_D DATA_WIDTH RF read data; Rd_D_Vld 1 RF read strobe.
REQ-006 Outputs: WR_DATA DATA_WIDTH FIFO word; WR_INC 1 FIFO push; ALU_EN 1 ALU start; ALU_FUN 4 ALU function; Wr_D DATA_WIDTH RF write data; Addr ADDR_WIDTH RF address; WrEn 1 RF write; RdEn 1 RF read; CLK_EN 1 ALU clock-gate enable; CLK_DIV_EN 1 divider enable; ERR 1 one-cycle error pulse.

Function
REQ-007 Commands (first frame byte): 0xAA RF write {addr,data}; 0xBB RF read {addr}; 0xCC ALU with operands {A,B,fun}; 0xDD ALU {fun}; 0xEE burst write {addr,N,N data}; 0xFF burst read {addr,N}.
REQ-008 FSM states: IDLE, GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN, RF_WR, RF_RD, WAIT_RD, PUSH, ALU_ISSUE, WAIT_ALU, PUSH_LO, PUSH_HI.
REQ-009 Unknown command byte in IDLE: byte dropped, ERR pulses next cycle, FSM stays IDLE.
REQ-010 RF write: WrEn high exactly one cycle with Addr/Wr_D stable, one cycle after data byte accepted.
REQ-011 RF read: RdEn high one cycle; WAIT_RD until Rd_D_Vld; Rd_D captured; then PUSH.
REQ-012 PUSH/PUSH_LO/PUSH_HI: WR_INC high one cycle with WR_DATA valid only when FIFO_FULL low; while FIFO_FULL high, FSM stalls, WR_INC low, WR_DATA held.
REQ-013 0xCC: A written to address 0, B to address 1 (one WrEn pulse each), then ALU_ISSUE.
REQ-014 ALU_ISSUE: ALU_EN high one cycle with ALU_FUN = low 4 bits of fun byte; CLK_EN high from ALU_ISSUE through the cycle OUT_Valid is seen.
REQ-015 On OUT_Valid, ALU_OUT captured; PUSH_LO pushes bits [DATA_WIDTH-1:0], PUSH_HI pushes [2*DATA_WIDTH-1:DATA_WIDTH].
REQ-016 Burst write: each data byte produces one WrEn pulse, address post-incremented modulo 2^ADDR_WIDTH.
REQ-017 Burst read: N read/push pairs, address post-incremented modulo 2^ADDR_WIDTH; each push obeys REQ-012.
REQ-018 N=0: frame ends after count byte, no RF access, no ERR, return to IDLE.
REQ-019 Timeout: in any GET_* state, counter increments each cycle without RX_D_VLD, clears on RX_D_VLD; on reaching TIMEOUT_CYCLES, ERR pulses, FSM returns IDLE, partial frame discarded (completed burst writes stand).
REQ-020 RX_D_VLD in non-GET, non-IDLE states: byte dropped, ERR pulses, operation continues.
REQ-021 CLK_DIV_EN SHALL be 1 in every non-reset cycle.

Reset
REQ-022 RST low asynchronously forces IDLE, clears counters and captured data, at any point including mid-frame or mid-push.
REQ-023 Reset values: WR_DATA, Wr_D, Addr, ALU_FUN = 0; WR_INC, ALU_EN, WrEn, RdEn, CLK_EN, ERR = 0; CLK_DIV_EN = 1.

Structure
REQ-024 Command codes, state enum and ALU operand addresses SHALL live in shared package sys_ctrl_pkg.
REQ-025 The inter-byte timeout counter SHALL be sub-module frame_timer (inputs: run, kick; output: expired).

Verification (DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-026 Bytes AA,05,3C -> one WrEn pulse, Addr=5, Wr_D=0x3C; no WR_INC.
REQ-027 Bytes BB,05, RF returns 0x3C, FIFO_FULL high 10 cycles -> WR_INC held off, then one pulse with WR_DATA=0x3C.
REQ-028 Bytes CC,12,34,00, ALU_OUT=0x0046 -> WrEn at Addr 0 (0x12) and 1 (0x34), ALU_EN with ALU_FUN=0, pushes 0x46 then 0x00.
REQ-029 Bytes EE,0E,03,11,22,33 -> writes 0x11@14, 0x22@15, 0x33@0 (wrap).
REQ-030 Bytes FF,02 then silence 1024 cycles -> ERR one pulse, IDLE, no RdEn; next AA frame executes normally.
REQ-031 Byte 7E -> ERR pulse, no outputs; RST asserted mid burst read -> all outputs at reset values immediately.
